sobel_controller: RTL and testbench

SOBEL_CONTROLLER -- requirements
Module: sobel_controller

---
 rtl/sobel_controller.sv | 181 ++++++++++++++++++
 tb/tb_sobel_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_controller.sv
// Sobel edge-detector frame controller.
// Sequences one frame through clear, receive, convolve and send phases by
// driving the counter/memory controls of an external datapath.
module sobel_controller #(
  parameter int IMG_X_SIZE = 100,
  parameter int IMG_Y_SIZE = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic abort_i,
  input  logic validIn_i,
  output logic readyIn_o,
  output logic validOut_o,
  input  logic readyOut_i,
  input  logic inputRecieved_i,
  input  logic kernelResReady_i,
  input  logic imageProcessed_i,
  output logic cntrInputClear_o,
  output logic cntrKernelClear_o,
  output logic cntrMemGclear_o,
  output logic memGclear_o,
  output logic memImgWr_o,
  output logic cntrInputInc_o,
  output logic saveImgOrCalculate_o,
  output logic cntrKernelInc_o,
  output logic memGwr_o,
  output logic cntrMemGinc_o,
  output logic dataAvailable_o,
  output logic busy_o,
  output logic done_o,
  output logic [$clog2((IMG_X_SIZE-2)*(IMG_Y_SIZE-2)+1)-1:0] sentCount_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CLR_G = 3'd2,
    RECV  = 3'd3,
    CALC  = 3'd4,
    SEND  = 3'd5,
    DONE  = 3'd6
  } stateT;

  stateT state;
  stateT nextState;
  logic  sentClear;
  logic  sentInc;

  // State register and count of output pixels accepted in this frame.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      sentCount_o <= '0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // the pre-edge value of every other flop.
      state <= nextState;
      if (sentClear) begin
        sentCount_o <= '0;
      end else if (sentInc) begin
        sentCount_o <= sentCount_o + 1'b1;
      end
    end
  end

  // Next-state and datapath controls; abort overrides every phase.
  always_comb begin
    // NOTE: every signal written here is defaulted first so no branch can
    // leave one unassigned and infer a latch.
    nextState            = state;
    readyIn_o            = 1'b0;
    validOut_o           = 1'b0;
    cntrInputClear_o     = 1'b0;
    cntrKernelClear_o    = 1'b0;
    cntrMemGclear_o      = 1'b0;
    memGclear_o          = 1'b0;
    memImgWr_o           = 1'b0;
    cntrInputInc_o       = 1'b0;
    saveImgOrCalculate_o = 1'b0;
    cntrKernelInc_o      = 1'b0;
    memGwr_o             = 1'b0;
    cntrMemGinc_o        = 1'b0;
    done_o               = 1'b0;
    sentClear            = 1'b0;
    sentInc              = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) nextState = INIT;
      end
      INIT: begin
        cntrInputClear_o  = 1'b1;
        cntrKernelClear_o = 1'b1;
        cntrMemGclear_o   = 1'b1;
        sentClear         = 1'b1;
        nextState         = CLR_G;
      end
      CLR_G: begin
        // The input counter doubles as the G-memory clear address.
        memGclear_o = 1'b1;
        if (inputRecieved_i) begin
          cntrInputClear_o = 1'b1;
          nextState        = RECV;
        end else begin
          cntrInputInc_o = 1'b1;
        end
      end
      RECV: begin
        readyIn_o = 1'b1;
        if (validIn_i) begin
          memImgWr_o = 1'b1;
          if (inputRecieved_i) begin
            cntrInputClear_o  = 1'b1;
            cntrKernelClear_o = 1'b1;
            cntrMemGclear_o   = 1'b1;
            nextState         = CALC;
          end else begin
            cntrInputInc_o = 1'b1;
          end
        end
      end
      CALC: begin
        // One kernel tap accumulated into G memory per cycle.
        saveImgOrCalculate_o = 1'b1;
        memGwr_o             = 1'b1;
        if (!kernelResReady_i) begin
          cntrKernelInc_o = 1'b1;
        end else begin
          cntrKernelClear_o = 1'b1;
          if (imageProcessed_i) begin
            cntrMemGclear_o = 1'b1;
            nextState       = SEND;
          end else begin
            cntrMemGinc_o = 1'b1;
          end
        end
      end
      SEND: begin
        validOut_o = 1'b1;
        if (readyOut_i) begin
          sentInc = 1'b1;
          if (imageProcessed_i) begin
            cntrMemGclear_o = 1'b1;
            nextState       = DONE;
          end else begin
            cntrMemGinc_o = 1'b1;
          end
        end
      end
      DONE: begin
        done_o    = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase

    if (abort_i && (state != IDLE)) begin
      readyIn_o            = 1'b0;
      validOut_o           = 1'b0;
      memGclear_o          = 1'b0;
      memImgWr_o           = 1'b0;
      cntrInputInc_o       = 1'b0;
      saveImgOrCalculate_o = 1'b0;
      cntrKernelInc_o      = 1'b0;
      memGwr_o             = 1'b0;
      cntrMemGinc_o        = 1'b0;
      done_o               = 1'b0;
      sentClear            = 1'b0;
      sentInc              = 1'b0;
      cntrInputClear_o     = 1'b1;
      cntrKernelClear_o    = 1'b1;
      cntrMemGclear_o      = 1'b1;
      nextState            = IDLE;
    end
  end

  assign dataAvailable_o = validOut_o;
  assign busy_o          = (state != IDLE);

endmodule

// File: tb/tb_sobel_controller.sv
// Bench for sobel_controller on a 4x4 image with a behavioural datapath:
// counters, image memory and G accumulators driven by the controller.
module tb_sobel_controller;

  localparam int XS   = 4;
  localparam int YS   = 4;
  localparam int NPIX = XS * YS;
  localparam int NOUT = (XS - 2) * (YS - 2);

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0, abort_i = 1'b0, validIn_i = 1'b0, readyOut_i = 1'b0;
  logic readyIn_o, validOut_o;
  logic inputRecieved_i, kernelResReady_i, imageProcessed_i;
  logic cntrInputClear_o, cntrKernelClear_o, cntrMemGclear_o, memGclear_o, memImgWr_o;
  logic cntrInputInc_o, saveImgOrCalculate_o, cntrKernelInc_o, memGwr_o, cntrMemGinc_o;
  logic dataAvailable_o, busy_o, done_o;
  logic [2:0] sentCount_o;
  logic [17:0] allOut;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  sobel_controller #(.IMG_X_SIZE(XS), .IMG_Y_SIZE(YS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .validIn_i(validIn_i), .readyIn_o(readyIn_o),
    .validOut_o(validOut_o), .readyOut_i(readyOut_i),
    .inputRecieved_i(inputRecieved_i), .kernelResReady_i(kernelResReady_i),
    .imageProcessed_i(imageProcessed_i),
    .cntrInputClear_o(cntrInputClear_o), .cntrKernelClear_o(cntrKernelClear_o),
    .cntrMemGclear_o(cntrMemGclear_o), .memGclear_o(memGclear_o),
    .memImgWr_o(memImgWr_o), .cntrInputInc_o(cntrInputInc_o),
    .saveImgOrCalculate_o(saveImgOrCalculate_o), .cntrKernelInc_o(cntrKernelInc_o),
    .memGwr_o(memGwr_o), .cntrMemGinc_o(cntrMemGinc_o),
    .dataAvailable_o(dataAvailable_o), .busy_o(busy_o), .done_o(done_o),
    .sentCount_o(sentCount_o)
  );

  assign allOut = {readyIn_o, validOut_o, cntrInputClear_o, cntrKernelClear_o,
                   cntrMemGclear_o, memGclear_o, memImgWr_o, cntrInputInc_o,
                   saveImgOrCalculate_o, cntrKernelInc_o, memGwr_o, cntrMemGinc_o,
                   dataAvailable_o, busy_o, done_o, sentCount_o};

  // ---------------- datapath model ----------------
  int ci = 0, ck = 0, cg = 0;
  int img[NPIX];
  int memImg[NPIX];
  int accX[NPIX];
  int accY[NPIX];

  assign inputRecieved_i  = (ci == NPIX - 1);
  assign kernelResReady_i = (ck == 8);
  assign imageProcessed_i = (cg == NOUT - 1);

  function automatic int tapPix(int g, int k);
    return memImg[((g / (XS - 2)) + k / 3) * XS + (g % (XS - 2)) + k % 3];
  endfunction

  function automatic int wx(int k);
    return ((k % 3) - 1) * (((k / 3) == 1) ? 2 : 1);
  endfunction

  function automatic int wy(int k);
    return ((k / 3) - 1) * (((k % 3) == 1) ? 2 : 1);
  endfunction

  always @(posedge clk_i) begin
    if (cntrInputClear_o) ci <= 0; else if (cntrInputInc_o) ci <= ci + 1;
    if (cntrKernelClear_o) ck <= 0; else if (cntrKernelInc_o) ck <= ck + 1;
    if (cntrMemGclear_o) cg <= 0; else if (cntrMemGinc_o) cg <= cg + 1;
    if (memImgWr_o && ci >= 0 && ci < NPIX) memImg[ci] <= img[ci];
    if (memGclear_o && ci >= 0 && ci < NPIX) begin
      accX[ci] <= 0;
      accY[ci] <= 0;
    end
    if (memGwr_o && cg >= 0 && cg < NOUT && ck >= 0 && ck < 9) begin
      accX[cg] <= accX[cg] + wx(ck) * tapPix(cg, ck);
      accY[cg] <= accY[cg] + wy(ck) * tapPix(cg, ck);
    end
  end

  // ---------------- golden Sobel ----------------
  int KX[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int KY[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  function automatic int mag(int a, int b);
    int s;
    s = (a < 0 ? -a : a) + (b < 0 ? -b : b);
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int golden(int p);
    int ox, oy, sx, sy;
    ox = p % (XS - 2);
    oy = p / (XS - 2);
    sx = 0;
    sy = 0;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 3; i++) begin
        sx += KX[j * 3 + i] * img[(oy + j) * XS + ox + i];
        sy += KY[j * 3 + i] * img[(oy + j) * XS + ox + i];
      end
    return mag(sx, sy);
  endfunction

  // ---------------- frame driver / observer ----------------
  int nInit, nClr, nRecv, nCalc, nSend, nDone, nWr, nWrBad, nViol;
  int nStallCyc, nStallBad, nAbortBad;
  bit timedOut, abortSeen, rstHit;
  logic [17:0] rstOut;
  int outQ[$];

  task automatic randomImage();
    for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
  endtask

  task automatic runFrame(input int validMode, input int readyMode, input int stallAt,
                          input int abortAt, input int rstAt, input bit startHold);
    int calcIdx = 0;
    int recvIdx = 0;
    int stallLeft = 5;
    int stallCg = -1;
    bit fin = 0;
    bit stalling;
    nInit = 0; nClr = 0; nRecv = 0; nCalc = 0; nSend = 0; nDone = 0;
    nWr = 0; nWrBad = 0; nViol = 0; nStallCyc = 0; nStallBad = 0; nAbortBad = 0;
    abortSeen = 0; rstHit = 0; rstOut = '0;
    outQ.delete();
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      @(negedge clk_i);
      start_i = (cyc == 0) || startHold;
      abort_i = 1'b0;
      case (validMode)
        0:       validIn_i = 1'b1;
        1:       validIn_i = (recvIdx % 2 == 0);
        default: validIn_i = 1'($urandom_range(0, 1));
      endcase
      readyOut_i = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      stalling = 0;
      if (stallAt >= 0 && validOut_o && int'(sentCount_o) == stallAt && stallLeft > 0) begin
        readyOut_i = 1'b0;
        stallLeft--;
        stalling = 1;
      end
      if (abortAt >= 0 && saveImgOrCalculate_o && calcIdx == abortAt) abort_i = 1'b1;
      if (rstAt >= 0 && validOut_o && int'(sentCount_o) == rstAt) rst_i = 1'b0;
      #1;
      if (!rst_i) begin
        rstHit = 1;
        rstOut = allOut;
        fin = 1;
      end else begin
        if (busy_o && cntrInputClear_o && cntrKernelClear_o && cntrMemGclear_o && !abort_i &&
            !memGclear_o && !readyIn_o && !saveImgOrCalculate_o && !validOut_o && !done_o)
          nInit++;
        if (memGclear_o) nClr++;
        if (readyIn_o) begin nRecv++; recvIdx++; end
        if (saveImgOrCalculate_o) begin nCalc++; calcIdx++; end
        if (validOut_o) nSend++;
        if (done_o) begin nDone++; fin = 1; end
        if (memImgWr_o) nWr++;
        if (memImgWr_o && !validIn_i) nWrBad++;
        if ((cntrInputClear_o && cntrInputInc_o) || (cntrKernelClear_o && cntrKernelInc_o) ||
            (cntrMemGclear_o && cntrMemGinc_o) || (memImgWr_o && (memGwr_o || memGclear_o)) ||
            (dataAvailable_o !== validOut_o) || (readyIn_o && validOut_o) ||
            (validOut_o && !readyOut_i && cntrMemGinc_o) || (done_o && !busy_o))
          nViol++;
        if (validOut_o && readyOut_i && cg >= 0 && cg < NOUT)
          outQ.push_back(mag(accX[cg], accY[cg]));
        if (stalling) begin
          nStallCyc++;
          if (stallCg < 0) stallCg = cg;
          if (cntrMemGinc_o || cg != stallCg) nStallBad++;
        end
        if (abort_i) begin
          abortSeen = 1;
          fin = 1;
          if (!(cntrInputClear_o && cntrKernelClear_o && cntrMemGclear_o) || memImgWr_o ||
              memGwr_o || memGclear_o || cntrInputInc_o || cntrKernelInc_o || cntrMemGinc_o ||
              done_o)
            nAbortBad++;
        end
      end
    end
    timedOut = !fin;
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0; validIn_i = 1'b0; readyOut_i = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    rst_i = 1'b0;
    start_i = 1'b1; abort_i = 1'b1; validIn_i = 1'b1; readyOut_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); #1;
      total++;
      if (allOut !== '0) begin bad++; $display("FAIL reset_outputs cycle %0d: got %b want 0", i, allOut); end
    end
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0; validIn_i = 1'b0; readyOut_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i); #1;
    total++;
    if (allOut !== '0) begin bad++; $display("FAIL reset_release_idle: got %b want 0", allOut); end
  endtask

  task automatic test_basic_frame();
    randomImage();
    runFrame(0, 0, -1, -1, -1, 0);
    total++; if (timedOut) begin bad++; $display("FAIL basic_timeout: frame did not finish"); end
    total++; if (nInit != 1) begin bad++; $display("FAIL basic_init: got %0d want 1", nInit); end
    total++; if (nClr != 16) begin bad++; $display("FAIL basic_clr_g: got %0d want 16", nClr); end
    total++; if (nRecv != 16) begin bad++; $display("FAIL basic_recv: got %0d want 16", nRecv); end
    total++; if (nCalc != 36) begin bad++; $display("FAIL basic_calc: got %0d want 36", nCalc); end
    total++; if (nSend != 4) begin bad++; $display("FAIL basic_send: got %0d want 4", nSend); end
    total++; if (nDone != 1) begin bad++; $display("FAIL basic_done: got %0d want 1", nDone); end
    total++; if (nViol != 0) begin bad++; $display("FAIL basic_protocol: got %0d violations want 0", nViol); end
    total++; if (sentCount_o !== 3'd4) begin bad++; $display("FAIL basic_sent: got %0d want 4", sentCount_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_idle_after: busy %b want 0", busy_o); end
    total++; if (outQ.size() != NOUT) begin bad++; $display("FAIL basic_out_count: got %0d want %0d", outQ.size(), NOUT); end
    for (int i = 0; i < outQ.size(); i++) begin
      total++;
      if (outQ[i] != golden(i)) begin bad++; $display("FAIL basic_pixel %0d: got %0d want %0d", i, outQ[i], golden(i)); end
    end
  endtask

  task automatic test_toggle_valid();
    randomImage();
    runFrame(1, 0, -1, -1, -1, 0);
    total++; if (timedOut) begin bad++; $display("FAIL toggle_timeout: frame did not finish"); end
    total++; if (nRecv != 31) begin bad++; $display("FAIL toggle_recv: got %0d want 31", nRecv); end
    total++; if (nWr != 16) begin bad++; $display("FAIL toggle_writes: got %0d want 16", nWr); end
    total++; if (nWrBad != 0) begin bad++; $display("FAIL toggle_write_no_valid: got %0d want 0", nWrBad); end
    total++; if (sentCount_o !== 3'd4) begin bad++; $display("FAIL toggle_sent: got %0d want 4", sentCount_o); end
  endtask

  task automatic test_stall();
    randomImage();
    runFrame(0, 0, 2, -1, -1, 0);
    total++; if (timedOut) begin bad++; $display("FAIL stall_timeout: frame did not finish"); end
    total++; if (nStallCyc != 5) begin bad++; $display("FAIL stall_held: got %0d stalled cycles want 5", nStallCyc); end
    total++; if (nStallBad != 0) begin bad++; $display("FAIL stall_addr: got %0d moves want 0", nStallBad); end
    total++; if (nSend != 9) begin bad++; $display("FAIL stall_send: got %0d want 9", nSend); end
    total++; if (nViol != 0) begin bad++; $display("FAIL stall_protocol: got %0d want 0", nViol); end
    total++; if (sentCount_o !== 3'd4) begin bad++; $display("FAIL stall_sent: got %0d want 4", sentCount_o); end
    for (int i = 0; i < outQ.size(); i++) begin
      total++;
      if (outQ[i] != golden(i)) begin bad++; $display("FAIL stall_pixel %0d: got %0d want %0d", i, outQ[i], golden(i)); end
    end
  endtask

  task automatic test_images();
    for (int i = 0; i < NPIX; i++) img[i] = 10;
    runFrame(0, 0, -1, -1, -1, 0);
    total++; if (outQ.size() != NOUT) begin bad++; $display("FAIL flat_count: got %0d want %0d", outQ.size(), NOUT); end
    for (int i = 0; i < outQ.size(); i++) begin
      total++;
      if (outQ[i] != 0) begin bad++; $display("FAIL flat_pixel %0d: got %0d want 0", i, outQ[i]); end
    end
    for (int i = 0; i < NPIX; i++) img[i] = ((i % XS) < XS / 2) ? 0 : 255;
    runFrame(0, 0, -1, -1, -1, 0);
    total++; if (outQ.size() != NOUT) begin bad++; $display("FAIL edge_count: got %0d want %0d", outQ.size(), NOUT); end
    for (int i = 0; i < outQ.size(); i++) begin
      total++;
      if (outQ[i] != golden(i) || outQ[i] == 0)
        begin bad++; $display("FAIL edge_pixel %0d: got %0d want %0d", i, outQ[i], golden(i)); end
    end
  endtask

  task automatic test_abort();
    randomImage();
    runFrame(0, 0, -1, $urandom_range(0, 35), -1, 0);
    total++; if (!abortSeen) begin bad++; $display("FAIL abort_reached: abort never applied"); end
    total++; if (nAbortBad != 0) begin bad++; $display("FAIL abort_controls: got %0d bad cycles want 0", nAbortBad); end
    total++; if (nDone != 0) begin bad++; $display("FAIL abort_done: got %0d pulses want 0", nDone); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_idle: busy %b want 0", busy_o); end
    total++; if (sentCount_o !== 3'd0) begin bad++; $display("FAIL abort_sent: got %0d want 0", sentCount_o); end
    randomImage();
    runFrame(0, 0, -1, -1, -1, 0);
    total++; if (nDone != 1 || sentCount_o !== 3'd4)
      begin bad++; $display("FAIL abort_restart: done %0d sent %0d want 1 and 4", nDone, sentCount_o); end
    for (int i = 0; i < outQ.size(); i++) begin
      total++;
      if (outQ[i] != golden(i)) begin bad++; $display("FAIL abort_pixel %0d: got %0d want %0d", i, outQ[i], golden(i)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    randomImage();
    runFrame(0, 0, -1, -1, 1, 0);
    total++; if (!rstHit) begin bad++; $display("FAIL midrst_reached: reset never applied"); end
    total++; if (rstOut !== '0) begin bad++; $display("FAIL midrst_outputs: got %b want 0", rstOut); end
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #1;
      total++;
      if (allOut !== '0) begin bad++; $display("FAIL midrst_hold %0d: got %b want 0", i, allOut); end
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i); #1;
    total++;
    if (!(busy_o && cntrInputClear_o && cntrKernelClear_o && cntrMemGclear_o))
      begin bad++; $display("FAIL midrst_init: got %b want INIT clears", allOut); end
    abort_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk_i);
    abort_i = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_abort_idle: busy %b want 0", busy_o); end
    randomImage();
    runFrame(0, 0, -1, -1, -1, 0);
    total++; if (nDone != 1 || sentCount_o !== 3'd4)
      begin bad++; $display("FAIL midrst_next_frame: done %0d sent %0d want 1 and 4", nDone, sentCount_o); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      randomImage();
      runFrame(2, 2, -1, -1, -1, 1);
      total++; if (timedOut) begin bad++; $display("FAIL b2b_timeout frame %0d", f); end
      total++; if (nWr != 16 || nWrBad != 0)
        begin bad++; $display("FAIL b2b_writes frame %0d: got %0d/%0d want 16/0", f, nWr, nWrBad); end
      total++; if (nViol != 0) begin bad++; $display("FAIL b2b_protocol frame %0d: got %0d want 0", f, nViol); end
      total++; if (sentCount_o !== 3'd4) begin bad++; $display("FAIL b2b_sent frame %0d: got %0d want 4", f, sentCount_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL b2b_start_in_done frame %0d: busy %b want 0", f, busy_o); end
      for (int i = 0; i < outQ.size(); i++) begin
        total++;
        if (outQ[i] != golden(i)) begin bad++; $display("FAIL b2b_pixel %0d.%0d: got %0d want %0d", f, i, outQ[i], golden(i)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_toggle_valid();
    test_stall();
    test_images();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
